// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped BTB with 2-bit saturating counters.
// IF-stage lookup is combinational off the table flops; ID-stage resolution
// evaluates the branch condition, reports mispredicts and trains the table.
// Optional feature macro: BP_STATS_EN adds saturating branch/mispredict counters.
module branch_predict_unit #(
  parameter int          ADDR_W   = 16,
  parameter int          IDX_W    = 4,
  parameter logic [1:0]  CTR_INIT = 2'b01
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [ADDR_W-1:0] lkp_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_next_pc,
  input  logic              res_valid,
  input  logic [ADDR_W-1:0] res_pc,
  input  logic [2:0]        res_cond,
  input  logic [2:0]        res_flags,
  input  logic              res_is_jr,
  input  logic [ADDR_W-1:0] res_target,
  input  logic              res_pred_taken,
  input  logic [ADDR_W-1:0] res_pred_target,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [15:0]       stat_branches,
  output logic [15:0]       stat_mispred
`endif
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W;

  // Table state: kept in flops so the whole table can be cleared in one cycle
  logic              valid_reg  [DEPTH];
  logic [TAG_W-1:0]  tag_reg    [DEPTH];
  logic [ADDR_W-1:0] target_reg [DEPTH];
  logic [1:0]        ctr_reg    [DEPTH];

  logic [IDX_W-1:0]  lkp_idx;
  logic [TAG_W-1:0]  lkp_tag;
  logic [IDX_W-1:0]  res_idx;
  logic [TAG_W-1:0]  res_tag;
  logic              res_hit;
  logic              cond_true;
  logic              actual_taken;
  logic [1:0]        ctr_next;
  logic [DEPTH-1:0]  wr_sel;

  assign lkp_idx = lkp_pc[IDX_W-1:0];
  assign lkp_tag = lkp_pc[ADDR_W-1:IDX_W];
  assign res_idx = res_pc[IDX_W-1:0];
  assign res_tag = res_pc[ADDR_W-1:IDX_W];

  // Lookup path: pre-edge table contents, no bypass from a concurrent update
  always_comb begin
    pred_hit     = valid_reg[lkp_idx] && (tag_reg[lkp_idx] == lkp_tag);
    pred_taken   = pred_hit && ctr_reg[lkp_idx][1];
    pred_next_pc = pred_taken ? target_reg[lkp_idx] : lkp_pc + ADDR_W'(1);
  end

  // Condition evaluation; flags are {N,V,Z}
  always_comb begin
    cond_true = 1'b0;
    case (res_cond)
      3'd0: cond_true = ~res_flags[0];
      3'd1: cond_true = res_flags[0];
      3'd2: cond_true = ~(res_flags[0] | res_flags[2]);
      3'd3: cond_true = res_flags[2];
      3'd4: cond_true = res_flags[0] | ~res_flags[2];
      3'd5: cond_true = res_flags[2] | res_flags[0];
      3'd6: cond_true = res_flags[1];
      default: cond_true = 1'b1;
    endcase
  end

  // Resolution outputs and the saturating counter step for the resolving entry
  always_comb begin
    actual_taken = res_is_jr | cond_true;
    mispredict   = res_valid & ((actual_taken != res_pred_taken) |
                   (actual_taken & res_pred_taken & (res_target != res_pred_target)));
    redirect_pc  = actual_taken ? res_target : res_pc + ADDR_W'(1);
    res_hit      = valid_reg[res_idx] && (tag_reg[res_idx] == res_tag);
    ctr_next     = ctr_reg[res_idx];
    if (actual_taken) begin
      if (ctr_reg[res_idx] != 2'b11) ctr_next = ctr_reg[res_idx] + 2'd1;
    end else begin
      if (ctr_reg[res_idx] != 2'b00) ctr_next = ctr_reg[res_idx] - 2'd1;
    end
  end

  // Per-entry write select: flush suppresses training, not-taken misses never allocate
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_sel
      assign wr_sel[gi] = res_valid && !flush && (res_idx == IDX_W'(gi)) &&
                          (res_hit || actual_taken);
    end
  endgenerate

  // Table update: async clear, flush clears valids, otherwise train the selected entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_reg[i]  <= 1'b0;
        tag_reg[i]    <= '0;
        target_reg[i] <= '0;
        ctr_reg[i]    <= CTR_INIT;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_reg[i] <= 1'b0;
        ctr_reg[i]   <= CTR_INIT;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) begin
          if (res_hit) begin
            ctr_reg[i] <= ctr_next;
            if (actual_taken) target_reg[i] <= res_target;
          end else begin
            valid_reg[i]  <= 1'b1;
            tag_reg[i]    <= res_tag;
            target_reg[i] <= res_target;
            ctr_reg[i]    <= 2'b10;
          end
        end
      end
    end
  end

`ifdef BP_STATS_EN
  logic [15:0] stat_branches_reg;
  logic [15:0] stat_mispred_reg;

  assign stat_branches = stat_branches_reg;
  assign stat_mispred  = stat_mispred_reg;

  // Saturating statistics; only rst_n clears them, flush leaves them alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_reg <= '0;
      stat_mispred_reg  <= '0;
    end else if (res_valid) begin
      if (stat_branches_reg != 16'hFFFF) stat_branches_reg <= stat_branches_reg + 16'd1;
      if (mispredict && (stat_mispred_reg != 16'hFFFF))
        stat_mispred_reg <= stat_mispred_reg + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed testbench for branch_predict_unit (stats checks compiled with BP_STATS_EN).
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [15:0] lkp_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [15:0] pred_next_pc;
  logic        res_valid;
  logic [15:0] res_pc;
  logic [2:0]  res_cond;
  logic [2:0]  res_flags;
  logic        res_is_jr;
  logic [15:0] res_target;
  logic        res_pred_taken;
  logic [15:0] res_pred_target;
  logic        mispredict;
  logic [15:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [15:0] stat_branches;
  logic [15:0] stat_mispred;
`endif

  int total = 0;
  int bad   = 0;

  branch_predict_unit #(.ADDR_W(16), .IDX_W(4), .CTR_INIT(2'b01)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .lkp_pc(lkp_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
    .res_valid(res_valid), .res_pc(res_pc), .res_cond(res_cond), .res_flags(res_flags),
    .res_is_jr(res_is_jr), .res_target(res_target), .res_pred_taken(res_pred_taken),
    .res_pred_target(res_pred_target), .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BP_STATS_EN
    , .stat_branches(stat_branches), .stat_mispred(stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs are then driven 1ns after the posedge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_res(input logic v, input logic [15:0] pc, input logic [2:0] c,
                         input logic [2:0] f, input logic jr, input logic [15:0] tgt,
                         input logic pt, input logic [15:0] ptgt);
    res_valid = v; res_pc = pc; res_cond = c; res_flags = f; res_is_jr = jr;
    res_target = tgt; res_pred_taken = pt; res_pred_target = ptgt;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; lkp_pc = 16'h0010;
    set_res(1'b0, 16'h0, 3'd0, 3'd0, 1'b0, 16'h0, 1'b0, 16'h0);
    #12 rst_n = 1'b1;
    #1;
    total++; if (pred_hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%b exp=0", pred_hit); end
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL reset_taken got=%b exp=0", pred_taken); end
    total++; if (pred_next_pc !== 16'h0011) begin bad++; $display("FAIL reset_next got=%h exp=0011", pred_next_pc); end
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL reset_misp got=%b exp=0", mispredict); end
    $display("reset: hit=%b taken=%b next=%h", pred_hit, pred_taken, pred_next_pc);
  endtask

  task automatic test_allocate;
    tick;
    set_res(1'b1, 16'h0010, 3'd7, 3'd0, 1'b0, 16'h0040, 1'b0, 16'h0000);
    #1;
    total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL alloc_misp got=%b exp=1", mispredict); end
    total++; if (redirect_pc !== 16'h0040) begin bad++; $display("FAIL alloc_redirect got=%h exp=0040", redirect_pc); end
    total++; if (pred_hit !== 1'b0) begin bad++; $display("FAIL alloc_prewrite_hit got=%b exp=0", pred_hit); end
    tick;
    res_valid = 1'b0;
    #1;
    total++; if (pred_hit !== 1'b1) begin bad++; $display("FAIL alloc_hit got=%b exp=1", pred_hit); end
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL alloc_taken got=%b exp=1", pred_taken); end
    total++; if (pred_next_pc !== 16'h0040) begin bad++; $display("FAIL alloc_next got=%h exp=0040", pred_next_pc); end
    $display("allocate: redirect=%h next=%h", redirect_pc, pred_next_pc);
  endtask

  task automatic test_counter;
    logic [2:0] exp_m;
    exp_m = 3'b001;
    for (int k = 0; k < 3; k++) begin
      tick;
      set_res(1'b1, 16'h0010, 3'd1, 3'd0, 1'b0, 16'h0099, (k == 0), 16'h0040);
      #1;
      total++; if (mispredict !== exp_m[k]) begin bad++; $display("FAIL ctr_misp%0d got=%b exp=%b", k, mispredict, exp_m[k]); end
      total++; if (redirect_pc !== 16'h0011) begin bad++; $display("FAIL ctr_redirect%0d got=%h exp=0011", k, redirect_pc); end
      if (k > 0) begin
        total++; if (pred_taken !== 1'b0 || pred_hit !== 1'b1) begin bad++; $display("FAIL ctr_lookup%0d got hit=%b taken=%b exp hit=1 taken=0", k, pred_hit, pred_taken); end
      end
      $display("counter resolve %0d: misp=%b taken=%b", k, mispredict, pred_taken);
    end
    tick;
    res_valid = 1'b0;
    #1;
    total++; if (pred_taken !== 1'b0 || pred_next_pc !== 16'h0011) begin bad++; $display("FAIL ctr_sat_lo got taken=%b next=%h exp 0/0011", pred_taken, pred_next_pc); end
    set_res(1'b1, 16'h0010, 3'd7, 3'd0, 1'b0, 16'h0040, 1'b0, 16'h0000);
    tick;
    res_valid = 1'b0;
    #1;
    total++; if (pred_taken !== 1'b0 || pred_hit !== 1'b1) begin bad++; $display("FAIL ctr_one_up got hit=%b taken=%b exp 1/0", pred_hit, pred_taken); end
    $display("counter: after 00 + taken, taken=%b", pred_taken);
  endtask

  task automatic test_alias;
    set_res(1'b1, 16'h0110, 3'd7, 3'd0, 1'b0, 16'h0055, 1'b0, 16'h0000);
    tick;
    res_valid = 1'b0;
    lkp_pc = 16'h0010;
    #1;
    total++; if (pred_hit !== 1'b0 || pred_next_pc !== 16'h0011) begin bad++; $display("FAIL alias_old got hit=%b next=%h exp 0/0011", pred_hit, pred_next_pc); end
    lkp_pc = 16'h0110;
    #1;
    total++; if (pred_hit !== 1'b1 || pred_next_pc !== 16'h0055) begin bad++; $display("FAIL alias_new got hit=%b next=%h exp 1/0055", pred_hit, pred_next_pc); end
    $display("alias: new entry next=%h", pred_next_pc);
  endtask

  task automatic test_flush_same_cycle;
    flush = 1'b1;
    set_res(1'b1, 16'h0003, 3'd7, 3'd0, 1'b0, 16'h0077, 1'b0, 16'h0000);
    tick;
    flush = 1'b0; res_valid = 1'b0; lkp_pc = 16'h0003;
    #1;
    total++; if (pred_hit !== 1'b0) begin bad++; $display("FAIL flush_noalloc got=%b exp=0", pred_hit); end
    lkp_pc = 16'h0110;
    #1;
    total++; if (pred_hit !== 1'b0) begin bad++; $display("FAIL flush_clear got=%b exp=0", pred_hit); end
    lkp_pc = 16'h0003;
    set_res(1'b1, 16'h0003, 3'd7, 3'd0, 1'b0, 16'h0077, 1'b0, 16'h0000);
    tick;
    res_target = 16'h0088; res_pred_taken = 1'b1; res_pred_target = 16'h0077;
    #1;
    total++; if (pred_hit !== 1'b1 || pred_next_pc !== 16'h0077) begin bad++; $display("FAIL same_cycle_old got hit=%b next=%h exp 1/0077", pred_hit, pred_next_pc); end
    tick;
    res_valid = 1'b0;
    #1;
    total++; if (pred_next_pc !== 16'h0088) begin bad++; $display("FAIL same_cycle_new got=%h exp=0088", pred_next_pc); end
    $display("flush/same-cycle: next=%h", pred_next_pc);
  endtask

  task automatic test_wrap_and_target;
    lkp_pc = 16'hFFFF;
    set_res(1'b1, 16'hFFFF, 3'd1, 3'd0, 1'b0, 16'h1111, 1'b0, 16'h0000);
    #1;
    total++; if (pred_next_pc !== 16'h0000) begin bad++; $display("FAIL wrap_next got=%h exp=0000", pred_next_pc); end
    total++; if (redirect_pc !== 16'h0000 || mispredict !== 1'b0) begin bad++; $display("FAIL wrap_redirect got=%h misp=%b exp 0000/0", redirect_pc, mispredict); end
    tick;
    res_valid = 1'b0;
    #1;
    total++; if (pred_hit !== 1'b0) begin bad++; $display("FAIL nt_miss_noalloc got=%b exp=0", pred_hit); end
    set_res(1'b1, 16'h0005, 3'd7, 3'd0, 1'b0, 16'h0040, 1'b1, 16'h0041);
    #1;
    total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL tgt_mismatch got=%b exp=1", mispredict); end
    res_pred_target = 16'h0040;
    #1;
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL tgt_match got=%b exp=0", mispredict); end
    res_valid = 1'b0; res_pred_taken = 1'b0;
    #1;
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL misp_novalid got=%b exp=0", mispredict); end
    $display("wrap/target checks done");
  endtask

  task automatic test_cond_sweep;
    logic [7:0] tbl [8];
    logic       exp_t;
    // Row = cond, bit f = expected result for flags f ({N,V,Z})
    tbl[0] = 8'b0101_0101; // NE: ~Z
    tbl[1] = 8'b1010_1010; // EQ: Z
    tbl[2] = 8'b0000_0101; // GT: ~Z & ~N
    tbl[3] = 8'b1111_0000; // LT: N
    tbl[4] = 8'b1010_1111; // GE: Z | ~N
    tbl[5] = 8'b1111_1010; // LE: N | Z
    tbl[6] = 8'b1100_1100; // OV: V
    tbl[7] = 8'b1111_1111; // UN
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        tick;
        set_res(1'b1, 16'h2007, 3'(c), 3'(f), 1'b0, 16'h1234, 1'b0, 16'h0000);
        #1;
        exp_t = tbl[c][f];
        total++;
        if (mispredict !== exp_t || redirect_pc !== (exp_t ? 16'h1234 : 16'h2008)) begin
          bad++; $display("FAIL cond c=%0d f=%0d got misp=%b redir=%h exp taken=%b", c, f, mispredict, redirect_pc, exp_t);
        end
        tick;
        res_is_jr = 1'b1;
        #1;
        total++;
        if (mispredict !== 1'b1 || redirect_pc !== 16'h1234) begin
          bad++; $display("FAIL jr c=%0d f=%0d got misp=%b redir=%h exp 1/1234", c, f, mispredict, redirect_pc);
        end
        $display("sweep c=%0d f=%0d misp=%b", c, f, mispredict);
      end
    end
    res_valid = 1'b0; res_is_jr = 1'b0;
  endtask

  task automatic test_async_reset;
    tick;
    lkp_pc = 16'h0003;
    #1;
    total++; if (pred_hit !== 1'b1) begin bad++; $display("FAIL pre_reset_hit got=%b exp=1", pred_hit); end
    set_res(1'b1, 16'h0020, 3'd7, 3'd0, 1'b0, 16'h0066, 1'b0, 16'h0000);
    #2 rst_n = 1'b0;
    #1;
    total++; if (pred_hit !== 1'b0) begin bad++; $display("FAIL async_clear got=%b exp=0", pred_hit); end
    tick;
    res_valid = 1'b0;
    #2 rst_n = 1'b1;
    lkp_pc = 16'h0020;
    #1;
    total++; if (pred_hit !== 1'b0) begin bad++; $display("FAIL inflight_lost got=%b exp=0", pred_hit); end
    $display("async reset: hit=%b", pred_hit);
  endtask

`ifdef BP_STATS_EN
  task automatic test_stats;
    tick;
    total++; if (stat_branches !== 16'd0 || stat_mispred !== 16'd0) begin bad++; $display("FAIL stats_reset got=%0d/%0d exp 0/0", stat_branches, stat_mispred); end
    for (int k = 0; k < 5; k++) begin
      set_res(1'b1, 16'(16'h0030 + k), 3'd7, 3'd0, 1'b0, 16'h0050, (k >= 2), 16'h0050);
      tick;
    end
    res_valid = 1'b0;
    total++; if (stat_branches !== 16'd5 || stat_mispred !== 16'd2) begin bad++; $display("FAIL stats_count got=%0d/%0d exp 5/2", stat_branches, stat_mispred); end
    flush = 1'b1;
    tick;
    flush = 1'b0;
    total++; if (stat_branches !== 16'd5) begin bad++; $display("FAIL stats_flush got=%0d exp=5", stat_branches); end
    set_res(1'b1, 16'h0040, 3'd7, 3'd0, 1'b0, 16'h0050, 1'b0, 16'h0000);
    for (int k = 0; k < 65533; k++) tick;
    total++; if (stat_branches !== 16'hFFFF || stat_mispred !== 16'hFFFF) begin bad++; $display("FAIL stats_reach got=%h/%h exp FFFF/FFFF", stat_branches, stat_mispred); end
    tick;
    res_valid = 1'b0;
    total++; if (stat_branches !== 16'hFFFF || stat_mispred !== 16'hFFFF) begin bad++; $display("FAIL stats_sat got=%h/%h exp FFFF/FFFF", stat_branches, stat_mispred); end
    $display("stats: branches=%h mispred=%h", stat_branches, stat_mispred);
  endtask
`endif

  initial begin
    test_reset;
    test_allocate;
    test_counter;
    test_alias;
    test_flush_same_cycle;
    test_wrap_and_target;
    test_cond_sweep;
    test_async_reset;
`ifdef BP_STATS_EN
    test_stats;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
